// File: rtl/tlc_lamp_driver.sv
`timescale 1ns/1ps
// tlc_lamp_driver: filters the controller state code, decodes it onto the
// three lamps, blinks yellow for BLANK, and latches a flashing-red fault on
// illegal codes until it is cleared. Also counts accepted state changes.
module tlc_lamp_driver #(
    parameter int unsigned BLINK_HALF    = 8,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic [2:0]       state,
    input  logic             fault_clr,
    output logic             lamp_red,
    output logic             lamp_yellow,
    output logic             lamp_green,
    output logic             fault,
    output logic [CNT_W-1:0] change_cnt
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'b000,
        ST_BLANK  = 3'b001,
        ST_RED    = 3'b010,
        ST_YELLOW = 3'b011,
        ST_GREEN  = 3'b100,
        ST_ILL5   = 3'b101,
        ST_ILL6   = 3'b110,
        ST_ILL7   = 3'b111
    } code_e;

    localparam int unsigned STAB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    code_e              acc_q, acc_d;
    code_e              cand_q, cand_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               phase_q, phase_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               red_q, red_d;
    logic               yel_q, yel_d;
    logic               grn_q, grn_d;

    code_e samp;
    logic  accept;
    logic  acc_chg;

    function automatic logic is_illegal(input code_e c);
        return c[2] & (c[1] | c[0]);
    endfunction

    // State register: all state resets asynchronously to the RED/lamp-on values.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            acc_q   <= ST_RED;
            cand_q  <= ST_RED;
            stab_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            red_q   <= 1'b1;
            yel_q   <= 1'b0;
            grn_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            red_q   <= red_d;
            yel_q   <= yel_d;
            grn_q   <= grn_d;
        end
    end

    // Next-state: glitch filter, blink generator, fault latch, counter and lamp decode.
    always_comb begin
        samp    = code_e'(state);
        cand_d  = samp;
        acc_d   = acc_q;
        stab_d  = STAB_W'(1);
        blink_d = blink_q;
        phase_d = phase_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        red_d   = 1'b0;
        yel_d   = 1'b0;
        grn_d   = 1'b0;

        // Run length includes the current sample and saturates once accepted.
        if (samp == cand_q) begin
            if (stab_q != STAB_W'(STABLE_CYCLES)) begin
                stab_d = stab_q + STAB_W'(1);
            end else begin
                stab_d = stab_q;
            end
        end
        accept  = (stab_d == STAB_W'(STABLE_CYCLES));
        acc_chg = accept && (samp != acc_q);

        if (acc_chg) begin
            acc_d = samp;
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Any acc change (which covers a fault being raised) restarts on-phase.
        if (acc_chg) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (blink_q == BLINK_W'(BLINK_HALF - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + BLINK_W'(1);
        end

        // Set has priority; a clear only takes while the held code is legal.
        if (acc_chg && is_illegal(samp)) begin
            fault_d = 1'b1;
        end else if (fault_clr && !is_illegal(acc_q)) begin
            fault_d = 1'b0;
        end

        // Lamps decode from next-state values so they move on the same edge as acc.
        if (fault_d) begin
            red_d = phase_d;
        end else begin
            unique case (acc_d)
                ST_BLANK:  yel_d = phase_d;
                ST_RED:    red_d = 1'b1;
                ST_YELLOW: yel_d = 1'b1;
                ST_GREEN:  grn_d = 1'b1;
                default:   ;
            endcase
        end
    end

    assign lamp_red    = red_q;
    assign lamp_yellow = yel_q;
    assign lamp_green  = grn_q;
    assign fault       = fault_q;
    assign change_cnt  = cnt_q;

endmodule

// File: tb/tb_tlc_lamp_driver.sv
`timescale 1ns/1ps
// Directed bench for tlc_lamp_driver (BLINK_HALF=8, STABLE_CYCLES=2, CNT_W=4).
module tb_tlc_lamp_driver;

    localparam logic [2:0] C_BLANK  = 3'b001;
    localparam logic [2:0] C_RED    = 3'b010;
    localparam logic [2:0] C_YELLOW = 3'b011;
    localparam logic [2:0] C_GREEN  = 3'b100;

    logic       pclk;
    logic       prst;
    logic [2:0] state;
    logic       fault_clr;
    logic       lamp_red, lamp_yellow, lamp_green, fault;
    logic [3:0] change_cnt;

    int checks   = 0;
    int failures = 0;

    tlc_lamp_driver #(
        .BLINK_HALF   (8),
        .STABLE_CYCLES(2),
        .CNT_W        (4)
    ) dut (
        .pclk       (pclk),
        .prst       (prst),
        .state      (state),
        .fault_clr  (fault_clr),
        .lamp_red   (lamp_red),
        .lamp_yellow(lamp_yellow),
        .lamp_green (lamp_green),
        .fault      (fault),
        .change_cnt (change_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected lamps given as {red, yellow, green}.
    task automatic chk_lamps(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, lamp_red, lamp_yellow, lamp_green}, {29'd0, exp});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_lamps({tag, "_lamps"}, 3'b100);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_cnt"}, {28'd0, change_cnt}, 32'd0);
    endtask

    initial begin
        prst      = 1'b1;
        state     = C_RED;
        fault_clr = 1'b0;
        #1;
        chk_reset_vals("reset");
        #10 prst = 1'b0;

        // Reset release with RED held.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_lamps("rel_lamps", 3'b100);
            chk("rel_cnt", {28'd0, change_cnt}, 32'd0);
            chk("rel_fault", {31'd0, fault}, 32'd0);
        end

        // Single-cycle GREEN glitch is filtered.
        state = C_GREEN;
        step();
        chk_lamps("glitch_a", 3'b100);
        state = C_RED;
        step();
        chk_lamps("glitch_b", 3'b100);
        step();
        chk("glitch_cnt", {28'd0, change_cnt}, 32'd0);

        // GREEN held: accepted on the second sampling edge.
        state = C_GREEN;
        step();
        chk_lamps("green_pend", 3'b100);
        step();
        chk_lamps("green_acc", 3'b001);
        chk("green_cnt", {28'd0, change_cnt}, 32'd1);

        // BLANK: 8 on, 8 off, 8 on, starting at acceptance.
        state = C_BLANK;
        step();
        chk_lamps("blank_pend", 3'b001);
        step();
        chk("blank_cnt", {28'd0, change_cnt}, 32'd2);
        for (int i = 0; i < 24; i++) begin
            if (i > 0) step();
            chk_lamps("blank_blink", {1'b0, ((i / 8) % 2) == 0, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk_lamps("blank_off", 3'b000);
        end

        // Switch to YELLOW mid off-phase: steady on from acceptance.
        state = C_YELLOW;
        step();
        chk_lamps("yel_pend", 3'b000);
        step();
        chk_lamps("yel_acc", 3'b010);
        chk("yel_cnt", {28'd0, change_cnt}, 32'd3);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_lamps("yel_steady", 3'b010);
        end

        // Illegal 110: fault with flashing red 8/8.
        state = 3'b110;
        step();
        chk("ill_pend_fault", {31'd0, fault}, 32'd0);
        chk_lamps("ill_pend", 3'b010);
        step();
        chk("ill_fault", {31'd0, fault}, 32'd1);
        chk("ill_cnt", {28'd0, change_cnt}, 32'd4);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            chk_lamps("ill_flash", {i < 8, 2'b00});
        end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("clr_ignored", {31'd0, fault}, 32'd1);
        chk_lamps("clr_ignored_lamp", 3'b100);

        // Back to RED, then clear: steady red.
        state = C_RED;
        step();
        step();
        chk("red_acc_fault", {31'd0, fault}, 32'd1);
        chk("red_acc_cnt", {28'd0, change_cnt}, 32'd5);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk_lamps("clr_lamp", 3'b100);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_lamps("clr_steady", 3'b100);
        end

        // Set and clear on the same edge: set wins.
        state = 3'b111;
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("same_edge_fault", {31'd0, fault}, 32'd1);
        chk("same_edge_cnt", {28'd0, change_cnt}, 32'd6);

        // Reset mid-blink during the off phase.
        for (int i = 0; i < 9; i++) step();
        chk_lamps("pre_rst_off", 3'b000);
        #2 prst = 1'b1;
        state = C_RED;
        #1;
        chk_reset_vals("async_rst1");
        #2 prst = 1'b0;

        // 17 accepted RED/GREEN changes: counter wraps to 1.
        for (int i = 1; i <= 17; i++) begin
            state = (i % 2 == 1) ? C_GREEN : C_RED;
            step();
            step();
            chk("wrap_cnt", {28'd0, change_cnt}, i % 16);
            chk_lamps("wrap_lamp", (i % 2 == 1) ? 3'b001 : 3'b100);
        end

        // Reset mid-filter; filter restarts from RED afterwards.
        state = C_RED;
        step();
        step();
        state = C_GREEN;
        step();
        #2 prst = 1'b1;
        #1;
        chk_reset_vals("async_rst2");
        #2 prst = 1'b0;
        step();
        chk_lamps("fresh_pend", 3'b100);
        chk("fresh_pend_cnt", {28'd0, change_cnt}, 32'd0);
        step();
        chk_lamps("fresh_acc", 3'b001);
        chk("fresh_cnt", {28'd0, change_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlc_lamp_driver.md
Name: tlc_lamp_driver

Overview:
- Downstream stage of the traffic light controller. Consumes the controller's 3-bit state code and drives the physical red, yellow and green lamp outputs.
- Filters glitches on the state code and generates the blink waveform for BLANK.
- Detects illegal state codes and forces a fail-safe flashing red until software clears the fault. Counts accepted state changes for diagnostics.

Parameters:
- BLINK_HALF, 8: cycles per half blink period (on time equals off time); minimum 1.
- STABLE_CYCLES, 2: consecutive sampled cycles a state code must hold before it is accepted; minimum 1.
- CNT_W, 16: width of the change counter.

Ports:
- pclk  input  1  clock.
- prst  input  1  asynchronous active-high reset.
- state  input  3  controller state code: OFF=000, BLANK=001, RED=010, YELLOW=011, GREEN=100. Codes 101..111 are illegal.
- fault_clr  input  1  single-cycle request to clear a sticky fault.
- lamp_red  output  1  red lamp drive, registered.
- lamp_yellow  output  1  yellow lamp drive, registered.
- lamp_green  output  1  green lamp drive, registered.
- fault  output  1  sticky illegal-code indicator.
- change_cnt  output  CNT_W  count of accepted state changes.

Behaviour:
- Reset (prst=1, takes effect immediately, no clock needed):
  - accepted state acc=RED; candidate=RED; stability counter=0.
  - lamp_red=1, lamp_yellow=0, lamp_green=0.
  - fault=0, change_cnt=0, blink counter=0, blink_phase=1.
- Glitch filter:
  - state is sampled every pclk edge.
  - A code held constant from sampling edge k is accepted into acc at edge k+STABLE_CYCLES-1.
  - Any differing sample restarts the count.
  - Re-acceptance of a code equal to acc is a no-op.
- Lamps are registered from acc, blink_phase and fault, and update on the same edge acc updates. At most one lamp is 1 in any cycle, including the cycle of a transition.
- Decode when fault=0:
  - OFF: all lamps 0.
  - BLANK: lamp_yellow=blink_phase; red and green 0.
  - RED: lamp_red only.
  - YELLOW: lamp_yellow only.
  - GREEN: lamp_green only.
- Decode when fault=1: lamp_red=blink_phase; yellow and green 0. This applies regardless of acc.
- Blink generator:
  - On every acc change, blink counter is set to 0 and blink_phase to 1, so the lamp is on first.
  - Otherwise the counter increments every cycle. At BLINK_HALF-1 it wraps to 0 and blink_phase toggles.
  - Result: the lamp is on for BLINK_HALF cycles, then off for BLINK_HALF cycles, repeating.
  - Setting fault also restarts the blink generator.
- Fault handling:
  - fault sets on the edge acc takes an illegal code. The acc change itself is still counted.
  - fault_clr clears fault only when acc holds a legal code; it is ignored while acc is illegal.
  - If set and clear occur on the same edge, set wins.
  - After a clear, lamps follow acc from the next edge.
- change_cnt increments by 1 on every edge where acc changes value (illegal codes included). It wraps modulo 2^CNT_W with no saturation.
- Reset asserted mid-blink or mid-filter returns everything immediately to the reset values. After release, the filter starts fresh from candidate=RED.

Test Plan:
- Reset release with state=RED held: lamp_red=1 throughout; change_cnt=0; fault=0.
- STABLE_CYCLES=2, acc=RED, state=GREEN for 1 cycle then back to RED: lamps unchanged, change_cnt=0. Then GREEN held: lamp_green=1 and lamp_red=0 at the second sampling edge, change_cnt=1, never two lamps on together.
- BLINK_HALF=8, state=BLANK held: after acceptance lamp_yellow=1 for 8 cycles, 0 for 8, 1 for 8; red and green stay 0. A switch to YELLOW mid-off-phase gives a steady lamp_yellow=1 from the acceptance edge.
- state=110 held: fault=1 at acceptance and lamp_red flashes 8 on / 8 off. fault_clr pulse while state=110: fault stays 1. state=RED accepted, then fault_clr: fault=0 and steady lamp_red=1 on the next edge.
- Same-edge fault set and fault_clr: drive 111 to acceptance with fault_clr=1 on that edge: fault=1.
- CNT_W=4: alternate RED/GREEN for 17 accepted changes: change_cnt wraps 15→0 and ends at 1. Assert prst mid-sequence: all outputs return to reset values asynchronously.
